// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared definitions for the 8-bit processor control path:
//               opcode encodings, sequencer state encodings and the default
//               instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

  localparam int unsigned IW_DEFAULT = 8;

  // 3-bit opcodes, taken from the top bits of the instruction register
  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_MFI = 3'b001;
  localparam logic [2:0] OP_MW  = 3'b010;
  localparam logic [2:0] OP_MR  = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_JCE = 3'b101;
  localparam logic [2:0] OP_MB  = 3'b110;
  localparam logic [2:0] OP_JCN = 3'b111;

  // Encodings 6 and 7 are unused and recover to IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Instruction-memory and data-memory handshake bundle.
//               master : sequencer side (drives requests)
//               slave  : memory side (drives acks and fetch data)
// Ports       : imem_req/imem_ack/imem_rdata  instruction fetch handshake
//               dmem_req/dmem_we/dmem_ack     data access handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int unsigned IW = 8
);
  logic          imem_req;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : op_decoder
// Description : Combinational opcode classification for the sequencer.
// Ports       : i_op          3-bit opcode
//               o_is_mem      MW/MR - needs a data memory phase
//               o_is_jump     J/JCE/JCN - resolved in EXEC
//               o_wr_en       register file writeback (MFI/MR/MB)
//               o_mem_to_reg  writeback from memory read data (MR)
//               o_sel_in      writeback from external input (MFI)
//               o_sel_out     register drives output port (R)
// Revision    : 1.0 - initial release
// ============================================================================
module op_decoder
  import instr_sequencer_pkg::*;
(
  input  wire logic [2:0] i_op,
  output logic            o_is_mem,
  output logic            o_is_jump,
  output logic            o_wr_en,
  output logic            o_mem_to_reg,
  output logic            o_sel_in,
  output logic            o_sel_out
);

  always_comb begin
    o_is_mem     = (i_op == OP_MW) || (i_op == OP_MR);
    o_is_jump    = (i_op == OP_J) || (i_op == OP_JCE) || (i_op == OP_JCN);
    o_wr_en      = (i_op == OP_MFI) || (i_op == OP_MR) || (i_op == OP_MB);
    o_mem_to_reg = (i_op == OP_MR);
    o_sel_in     = (i_op == OP_MFI);
    o_sel_out    = (i_op == OP_R);
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle control FSM: fetch, decode, execute/memory and
//               writeback, one phase per cycle. Datapath strobes are Moore
//               outputs of the current state and instruction register.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               i_run             continue executing (sampled at boundaries)
//               i_eq_flag         datapath comparator result
//               bus               memory handshakes (instr_sequencer_if.master)
//               o_ir              latched instruction
//               o_pc_inc/o_pc_load, o_reg_we, o_mem_to_reg, o_sel_in,
//               o_sel_out         datapath strobes
//               o_retire          pulse on last cycle of each instruction
//               o_state           current state (debug)
//               o_instr_count     retired-instruction count
// Config      : INSTR_COUNT_EN - when defined, o_instr_count counts retire
//               pulses (wrapping); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned IW    = IW_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_run,
  input  wire logic             i_eq_flag,
  instr_sequencer_if.master     bus,
  output logic [IW-1:0]         o_ir,
  output logic                  o_pc_inc,
  output logic                  o_pc_load,
  output logic                  o_reg_we,
  output logic                  o_mem_to_reg,
  output logic                  o_sel_in,
  output logic                  o_sel_out,
  output logic                  o_retire,
  output logic [2:0]            o_state,
  output logic [CNT_W-1:0]      o_instr_count
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ir;
  logic [2:0]    w_op;

  logic w_is_mem, w_is_jump, w_wr_en, w_mem_to_reg, w_sel_in, w_sel_out;

  assign w_op = r_ir[IW-1 -: 3];

  op_decoder u_op_decoder (
    .i_op         (w_op),
    .o_is_mem     (w_is_mem),
    .o_is_jump    (w_is_jump),
    .o_wr_en      (w_wr_en),
    .o_mem_to_reg (w_mem_to_reg),
    .o_sel_in     (w_sel_in),
    .o_sel_out    (w_sel_out)
  );

  // State register and instruction latch; reset drops any request at once
  // because all requests are decoded from r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_FETCH) && bus.imem_ack) begin
        r_ir <= bus.imem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    o_pc_inc     = 1'b0;
    o_pc_load    = 1'b0;
    o_reg_we     = 1'b0;
    o_mem_to_reg = 1'b0;
    o_sel_in     = 1'b0;
    o_sel_out    = 1'b0;
    o_retire     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_is_mem)       w_state_nxt = ST_MEM;
        else if (w_is_jump) w_state_nxt = ST_EXEC;
        else                w_state_nxt = ST_WB;
      end
      ST_EXEC: begin
        // Taken jump loads the target; a not-taken conditional just advances
        if ((w_op == OP_J) ||
            ((w_op == OP_JCE) &&  i_eq_flag) ||
            ((w_op == OP_JCN) && !i_eq_flag)) begin
          o_pc_load = 1'b1;
        end else begin
          o_pc_inc  = 1'b1;
        end
        o_retire    = 1'b1;
        w_state_nxt = i_run ? ST_FETCH : ST_IDLE;
      end
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (w_op == OP_MW);
        if (bus.dmem_ack) w_state_nxt = ST_WB;
      end
      ST_WB: begin
        o_pc_inc     = 1'b1;
        o_retire     = 1'b1;
        o_reg_we     = w_wr_en;
        o_mem_to_reg = w_mem_to_reg;
        o_sel_in     = w_sel_in;
        o_sel_out    = w_sel_out;
        w_state_nxt  = i_run ? ST_FETCH : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_ir    = r_ir;
  assign o_state = r_state;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (o_retire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_instr_count = r_count;
`else
  assign o_instr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer: a table of single
//               instructions with hand-computed latency and strobes, plus
//               hand-written sequences for reset, run-drop and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int unsigned IW    = 8;
  localparam int unsigned CNT_W = 4;
`ifdef INSTR_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             i_run;
  logic             i_eq_flag;
  logic [IW-1:0]    o_ir;
  logic             o_pc_inc, o_pc_load, o_reg_we, o_mem_to_reg;
  logic             o_sel_in, o_sel_out, o_retire;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_instr_count;

  instr_sequencer_if #(.IW(IW)) bus ();

  instr_sequencer #(.IW(IW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (i_run),
    .i_eq_flag     (i_eq_flag),
    .bus           (bus),
    .o_ir          (o_ir),
    .o_pc_inc      (o_pc_inc),
    .o_pc_load     (o_pc_load),
    .o_reg_we      (o_reg_we),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_sel_in      (o_sel_in),
    .o_sel_out     (o_sel_out),
    .o_retire      (o_retire),
    .o_state       (o_state),
    .o_instr_count (o_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector order: {pc_inc, pc_load, reg_we, mem_to_reg, sel_in, sel_out}
  typedef struct {
    logic [7:0] ir;
    logic       eq;
    int         imem_wait;
    int         dmem_wait;
    int         lat;
    logic [5:0] stb;
    int         dcyc;
    logic       we;
  } vec_t;

  vec_t vecs [12];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic logic [31:0] exp_count(input int n);
    return CNT_ON ? 32'(n % (1 << CNT_W)) : 32'd0;
  endfunction

  // Runs one instruction from IDLE with run dropped right after FETCH starts.
  task automatic run_vec(input vec_t v, input string name);
    int         cyc, iw, dc, lat, both;
    logic [5:0] stb;
    logic       we_seen;
    bit         done;
    i_run     = 1'b1;
    i_eq_flag = v.eq;
    @(posedge clk); @(negedge clk);
    i_run = 1'b0;
    cyc = 0; iw = 0; dc = 0; lat = 0; both = 0; stb = '0; we_seen = 1'b0; done = 0;
    while (!done && cyc < 50) begin
      cyc++;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = ~v.ir;
      bus.dmem_ack   = 1'b0;
      if (bus.imem_req) begin
        if (iw == v.imem_wait) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = v.ir;
        end else iw++;
      end
      if (bus.dmem_req) begin
        dc++;
        we_seen = bus.dmem_we;
        if (dc == v.dmem_wait + 1) bus.dmem_ack = 1'b1;
      end
      if (o_pc_inc && o_pc_load) both++;
      if (o_retire) begin
        done = 1;
        lat  = cyc;
        stb  = {o_pc_inc, o_pc_load, o_reg_we, o_mem_to_reg, o_sel_in, o_sel_out};
      end
      @(posedge clk); @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    if (done) n_retired++;
    chk({name, " latency"}, lat, v.lat);
    chk({name, " strobes"}, stb, v.stb);
    chk({name, " dmem_cycles"}, dc, v.dcyc);
    chk({name, " dmem_we"}, we_seen, v.we);
    chk({name, " ir"}, o_ir, v.ir);
    chk({name, " pc_inc&pc_load"}, both, 0);
    chk({name, " idle_after"}, {o_state, bus.imem_req}, {3'd0, 1'b0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_retired = 0;
  endtask

  initial begin
    vecs[0]  = '{8'h20, 1'b0, 0, 0, 3, 6'b101010, 0, 1'b0}; // MFI
    vecs[1]  = '{8'h60, 1'b0, 0, 3, 7, 6'b101100, 4, 1'b0}; // MR, 3 waits
    vecs[2]  = '{8'hA0, 1'b1, 0, 0, 3, 6'b010000, 0, 1'b0}; // JCE taken
    vecs[3]  = '{8'hA5, 1'b0, 0, 0, 3, 6'b100000, 0, 1'b0}; // JCE not taken
    vecs[4]  = '{8'hE0, 1'b1, 0, 0, 3, 6'b100000, 0, 1'b0}; // JCN not taken
    vecs[5]  = '{8'hE3, 1'b0, 0, 0, 3, 6'b010000, 0, 1'b0}; // JCN taken
    vecs[6]  = '{8'h80, 1'b0, 0, 0, 3, 6'b010000, 0, 1'b0}; // J
    vecs[7]  = '{8'h9F, 1'b1, 0, 0, 3, 6'b010000, 0, 1'b0}; // J
    vecs[8]  = '{8'h00, 1'b0, 2, 0, 5, 6'b100001, 0, 1'b0}; // R, 2 fetch waits
    vecs[9]  = '{8'h4C, 1'b0, 0, 0, 4, 6'b100000, 1, 1'b1}; // MW
    vecs[10] = '{8'hC7, 1'b0, 0, 0, 3, 6'b101000, 0, 1'b0}; // MB
    vecs[11] = '{8'h7F, 1'b0, 1, 1, 6, 6'b101100, 2, 1'b0}; // MR, waits both

    rst_n = 1'b0; i_run = 1'b0; i_eq_flag = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs",
        {o_state, o_ir, o_pc_inc, o_pc_load, o_reg_we, o_mem_to_reg, o_sel_in,
         o_sel_out, o_retire, bus.imem_req, bus.dmem_req, bus.dmem_we},
        '0);
    chk("reset count", o_instr_count, 0);
    rst_n = 1'b1;

    // Acks while idle must be ignored
    @(negedge clk);
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'hA5; bus.dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray ack state", o_state, 3'd0);
    chk("stray ack ir", o_ir, 8'h00);
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    chk("count after table", o_instr_count, exp_count(n_retired));

    // Reset while a data access is pending
    begin
      int k;
      i_run = 1'b1;
      @(posedge clk); @(negedge clk);
      i_run = 1'b0;
      k = 0;
      while (!bus.dmem_req && k < 20) begin
        bus.imem_ack   = bus.imem_req;
        bus.imem_rdata = 8'h60;
        @(posedge clk); @(negedge clk);
        k++;
      end
      bus.imem_ack = 1'b0;
      chk("pre-reset dmem_req", bus.dmem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async reset dmem_req", bus.dmem_req, 1'b0);
      chk("async reset state", o_state, 3'd0);
      chk("async reset ir", o_ir, 8'h00);
      chk("async reset count", o_instr_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n_retired = 0;
    end

    // run drops during DECODE of MW
    begin
      int rets, late_req;
      bit seen_ret;
      rets = 0; late_req = 0; seen_ret = 0;
      @(negedge clk);
      i_run = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (o_state == 3'd2) i_run = 1'b0;
        if (seen_ret && bus.imem_req) late_req++;
        bus.imem_ack   = bus.imem_req;
        bus.imem_rdata = 8'h4A;
        bus.dmem_ack   = bus.dmem_req;
        if (o_retire) begin rets++; seen_ret = 1; end
      end
      i_run = 1'b0;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      n_retired += 1;
      chk("run-drop retire pulses", rets, 1);
      chk("run-drop imem_req after", late_req, 0);
      chk("run-drop final state", o_state, 3'd0);
      chk("run-drop count", o_instr_count, exp_count(n_retired));
    end

    // 17 retirements wrap a 4-bit counter to 1
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      vec_t mb;
      mb = '{8'hC1, 1'b0, 0, 0, 3, 6'b101000, 0, 1'b0};
      run_vec(mb, $sformatf("mb%0d", i));
    end
    chk("count wrap", o_instr_count, CNT_ON ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
